// File: rtl/interfaz_round_robin_multimodo.sv
// Queue scheduler for the switch output selector: round robin, weighted, table-driven
// and strict-priority arbitration over per-queue FIFO empty flags.
module interfaz_round_robin_multimodo #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    parameter int TABLE_SIZE     = 8,
    localparam int W  = $clog2(MAX_WEIGHT),
    localparam int SW = $clog2(QUEUE_QUANTITY),
    localparam int PW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic [1:0]                 modo,
    input  logic [QUEUE_QUANTITY-1:0]  buf_empty,
    input  logic [QUEUE_QUANTITY*W-1:0] pesos,
    input  logic [TABLE_SIZE*SW-1:0]   selecciones,
    input  logic [TABLE_SIZE*W-1:0]    pesosArbitraje,
    output logic [SW-1:0]              selector,
    output logic                       selector_enb,
    output logic [1:0]                 modo_activo
);

    // Handshake: selector_enb is a valid strobe qualifying selector for one cycle; there is
    // no ready, the datapath consumes every cycle in which selector_enb is high.

    localparam logic [1:0] MODO_RR  = 2'b00;
    localparam logic [1:0] MODO_WRR = 2'b01;
    localparam logic [1:0] MODO_TBL = 2'b10;
    localparam logic [1:0] MODO_SP  = 2'b11;

    logic [W-1:0]  credit;
    logic [PW-1:0] ptr;
    logic [SW-1:0] last;
    logic          grant_valid;  // survives freezes, unlike selector_enb

    logic          boundary;
    logic [1:0]    modo_next;
    logic          rr_found, wrr_found, sp_found, t_empty, t_ok;
    logic [SW-1:0] rr_sel, wrr_sel, sp_sel, cand, t_q;
    logic [W-1:0]  wrr_w, t_w;
    logic [SW-1:0] nxt_sel, nxt_last;
    logic          nxt_valid;
    logic [W-1:0]  nxt_credit;
    logic [PW-1:0] nxt_ptr;

    always_comb begin
        boundary = (credit == '0) || buf_empty[selector] || !grant_valid ||
                   (modo_activo == MODO_RR) || (modo_activo == MODO_SP);
        modo_next = boundary ? modo : modo_activo;

        // Circular searches start just after the last granted queue.
        rr_found  = 1'b0;
        rr_sel    = last;
        wrr_found = 1'b0;
        wrr_sel   = last;
        wrr_w     = '0;
        cand      = '0;
        for (int off = 1; off <= QUEUE_QUANTITY; off++) begin
            cand = SW'((int'(last) + off) % QUEUE_QUANTITY);
            if (!rr_found && !buf_empty[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
            if (!wrr_found && !buf_empty[cand] && (pesos[int'(cand)*W +: W] != '0)) begin
                wrr_found = 1'b1;
                wrr_sel   = cand;
                wrr_w     = pesos[int'(cand)*W +: W];
            end
        end

        sp_found = 1'b0;
        sp_sel   = selector;
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (!buf_empty[i]) begin
                sp_found = 1'b1;
                sp_sel   = SW'(i);
            end
        end

        // Out-of-range table entries read as an empty queue.
        t_q     = selecciones[int'(ptr)*SW +: SW];
        t_w     = pesosArbitraje[int'(ptr)*W +: W];
        t_empty = 1'b1;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (int'(t_q) == i) t_empty = buf_empty[i];
        end
        t_ok = !t_empty && (t_w != '0);

        nxt_sel    = selector;
        nxt_valid  = 1'b0;
        nxt_credit = '0;
        nxt_last   = last;
        nxt_ptr    = ptr;
        if (!boundary) begin
            nxt_valid  = 1'b1;
            nxt_credit = credit - W'(1);
        end else begin
            case (modo_next)
                MODO_RR: if (rr_found) begin
                    nxt_sel   = rr_sel;
                    nxt_valid = 1'b1;
                    nxt_last  = rr_sel;
                end
                MODO_WRR: if (wrr_found) begin
                    nxt_sel    = wrr_sel;
                    nxt_valid  = 1'b1;
                    nxt_last   = wrr_sel;
                    nxt_credit = wrr_w - W'(1);
                end
                MODO_TBL: begin
                    // The pointer moves on as the entry is consumed, granted or skipped.
                    nxt_ptr = (ptr == PW'(TABLE_SIZE - 1)) ? '0 : ptr + PW'(1);
                    if (t_ok) begin
                        nxt_sel    = t_q;
                        nxt_valid  = 1'b1;
                        nxt_last   = t_q;
                        nxt_credit = t_w - W'(1);
                    end
                end
                default: if (sp_found) begin
                    nxt_sel   = sp_sel;
                    nxt_valid = 1'b1;
                    nxt_last  = sp_sel;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            selector     <= '0;
            selector_enb <= 1'b0;
            modo_activo  <= MODO_RR;
            credit       <= '0;
            ptr          <= '0;
            last         <= SW'(QUEUE_QUANTITY - 1);
            grant_valid  <= 1'b0;
        end else if (enb) begin
            selector     <= nxt_sel;
            selector_enb <= nxt_valid;
            modo_activo  <= modo_next;
            credit       <= nxt_credit;
            ptr          <= nxt_ptr;
            last         <= nxt_last;
            grant_valid  <= nxt_valid;
        end else begin
            selector_enb <= 1'b0;
        end
    end

endmodule

// File: doc/interfaz_round_robin_multimodo.md
Name: interfaz_round_robin_multimodo

Overview:
- Parametrised successor to the queue-scheduling interface. It picks which of QUEUE_QUANTITY output queues the mux/demux serves each cycle.
- It supports four modes: plain round robin, weighted round robin, table-driven arbitration, and a new strict-priority mode.
- It adds empty-queue skipping in every mode, mode and weight changes that take effect only at turn boundaries, and an enable freeze.
- It sits between the per-queue FIFO empty flags and the output selector of the switch datapath.

Parameters:
- QUEUE_QUANTITY, 4: number of queues; must be ≥2.
- MAX_WEIGHT, 64: weights are $clog2(MAX_WEIGHT) bits wide (W); weight value 0 means "skip".
- TABLE_SIZE, 8: number of entries in the arbitration table.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enb  in  1  block enable; 0 freezes all state.
- modo  in  2  requested mode: 00 round robin, 01 weighted, 10 table, 11 strict priority.
- buf_empty  in  QUEUE_QUANTITY  bit i = 1 when queue i is empty.
- pesos  in  QUEUE_QUANTITY*W  weight of queue i in bits [i*W +: W].
- selecciones  in  TABLE_SIZE*$clog2(QUEUE_QUANTITY)  queue index of table entry k.
- pesosArbitraje  in  TABLE_SIZE*W  cycle count of table entry k.
- selector  out  $clog2(QUEUE_QUANTITY)  granted queue index.
- selector_enb  out  1  grant valid this cycle.
- modo_activo  out  2  mode currently in force.

Behaviour:
- Reset (rst=0 at a clock edge): selector=0, selector_enb=0, modo_activo=00, credit counter=0, table pointer=0, last-granted register=QUEUE_QUANTITY-1. A reset mid-turn abandons the turn.
- Timing: all outputs are registered. Inputs sampled at edge t determine the outputs after edge t. Latency from buf_empty to selector is exactly 1 cycle.
- enb=0: all state holds, selector holds, selector_enb=0. When enb returns to 1, operation resumes with the remaining credit intact.
- Turn boundary occurs when any of the following holds:
  - credit reaches 0;
  - the granted queue is empty;
  - the block is idle (selector_enb=0);
  - mode 00 or 11 is active (every cycle is a boundary).
- Effects at a turn boundary:
  - modo is loaded into modo_activo;
  - the weight of the new turn is captured into the credit counter.
  - A modo or weight change mid-turn therefore has no effect until the boundary.
- Mode 00, round robin:
  - Grant the first non-empty queue after the last granted queue, searching circularly.
  - One cycle per grant. With a single non-empty queue, that queue is granted every cycle.
- Mode 01, weighted:
  - The next queue is chosen by the same circular search, but only queues that are non-empty and have a non-zero weight qualify.
  - The chosen queue is granted for pesos[i] consecutive cycles. Credit is loaded as weight-1 on the first grant cycle and decrements on each enabled grant cycle.
  - If the queue empties early, the turn ends and the next qualifying queue is granted in the following cycle.
- Mode 10, table:
  - Pointer p indexes entry p. The entry grants selecciones[p] for pesosArbitraje[p] cycles, then p increments, wrapping from TABLE_SIZE-1 to 0.
  - If the entry's queue is empty or its weight is 0: p advances, selector_enb=0 for that one cycle, and selector holds.
  - The pointer is retained across mode changes.
- Mode 11, strict priority: grant the lowest-index non-empty queue, re-evaluated every cycle. The last-granted register is updated.
- All queues empty, any mode: selector_enb=0, selector holds, credit is cleared. In mode 10, p keeps advancing one entry per cycle.
- Widths:
  - Credit counter is W bits; the full weight range 1..MAX_WEIGHT-1 is honoured.
  - Out-of-range selecciones values (only possible when QUEUE_QUANTITY is not a power of 2) are treated as an empty queue.

Test Plan:
- Weighted cycling:
  - Stimulus: rst released, modo=01, buf_empty=0000, pesos q0..q3 = 6,5,7,2.
  - Required: from the first cycle after release, selector is 0 ×6 cycles, 1 ×5, 2 ×7, 3 ×2, repeating with period 20; selector_enb=1 throughout.
- Round robin skip:
  - Stimulus: modo=00, buf_empty=0101.
  - Required: selector alternates 1,3,1,3; at every cycle selector is never 0 or 2.
- Strict priority and idle:
  - Stimulus: modo=11, buf_empty=0001.
  - Required: selector=1 every cycle.
  - Then buf_empty=1111: the next cycle has selector_enb=0 and selector holds at 1.
- Table with a skip:
  - Stimulus: modo=10; selecciones k0..k7 = 3,1,2,0,1,2,0,2; pesosArbitraje = 6,11,11,15,3,5,5,14; buf_empty=0100.
  - Required: entries 2, 5 and 7 each produce one selector_enb=0 cycle.
  - Required: queue 3 is granted 6 cycles, then queue 1 for 11 cycles, then one idle cycle, then queue 0 for 15 cycles, and so on.
- Freeze and deferred mode change:
  - Stimulus: in mode 01, queue 2 (weight 7) granted and 3 cycles elapsed; drive enb=0 for 10 cycles.
  - Required: selector_enb=0 during the freeze; afterwards queue 2 receives the remaining 4 cycles.
  - Stimulus: set modo=00 mid-turn.
  - Required: modo_activo changes only after those 4 cycles.
- Reset mid-turn:
  - Stimulus: drive rst=0 for one edge during a weighted turn.
  - Required: outputs return to reset values, and the first grant after release is queue 0.
